adc_serial_rx: RTL and testbench

//  Serial ADC frame controller and receiver; the consumer of the SCLK edge-enable strobes from the
//  ADC clock-enable generator. Drives ADC_CS_N, ADC_SCLK and ADC_DIN (channel select).

---
 rtl/adc_pkg.sv | 17 +
 rtl/adc_serial_rx_if.sv | 22 ++
 rtl/adc_din_sync.sv | 24 ++
 rtl/adc_serial_rx.sv | 146 ++++++++++++++
 tb/tb_adc_serial_rx.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_pkg.sv
// Shared types and frame constants for the serial ADC receiver.
package adc_pkg;

  localparam int unsigned ADC_FRAME_BITS = 16;
  localparam int unsigned ADC_DATA_W     = 12;
  localparam int unsigned ADC_ADDR_FIRST = 2;
  localparam int unsigned ADC_CNT_W      = 5;
  localparam int unsigned ADC_CH_W       = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } adc_state_e;

endpackage

// File: rtl/adc_serial_rx_if.sv
// ADC pin bundle plus the sample/status outputs toward the audio datapath.
interface adc_serial_rx_if;

  logic                            ADC_CS_N;
  logic                            ADC_SCLK;
  logic                            ADC_DIN;
  logic                            ADC_DOUT;
  logic [adc_pkg::ADC_DATA_W-1:0]  sample;
  logic                            sample_valid;
  logic                            busy;

  modport master (
    output ADC_CS_N, ADC_SCLK, ADC_DIN, sample, sample_valid, busy,
    input  ADC_DOUT
  );

  modport slave (
    input  ADC_CS_N, ADC_SCLK, ADC_DIN, sample, sample_valid, busy,
    output ADC_DOUT
  );

endinterface

// File: rtl/adc_din_sync.sv
// Two-flop synchroniser bringing ADC_DOUT into the clk_clk domain.
module adc_din_sync (
  input  logic clk_clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk_clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/adc_serial_rx.sv
// Serial ADC frame controller: drives CS_N/SCLK/DIN from SCLK edge strobes and captures a sample.
// Define ADC_CONT_EN for back-to-back frames while start stays high.
module adc_serial_rx
  import adc_pkg::*;
(
  input  logic                clk_clk,
  input  logic                reset_n,
  input  logic                PE_SCLK,
  input  logic                NE_SCLK,
  input  logic                start,
  input  logic [ADC_CH_W-1:0] channel,
  adc_serial_rx_if.master     adc
);

  localparam int unsigned DATA_W     = ADC_DATA_W;
  localparam int unsigned CNT_W      = ADC_CNT_W;
  localparam int unsigned ADDR_FIRST = ADC_ADDR_FIRST;
  localparam int unsigned FRAME_BITS = ADC_FRAME_BITS;

  adc_state_e          state_q, state_d;
  logic                cs_n_q, cs_n_d;
  logic                sclk_q, sclk_d;
  logic                din_q, din_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-2:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   sample_q, sample_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic [ADC_CH_W-1:0] ch_q, ch_d;

  logic       dout_s;
  logic       ne_hit;
  logic       addr_hit;
  logic [1:0] addr_idx;

  adc_din_sync u_din_sync (
    .clk_clk (clk_clk),
    .reset_n (reset_n),
    .d_i     (adc.ADC_DOUT),
    .q_o     (dout_s)
  );

  // NE strobe is active low; it takes priority over a coincident PE.
  assign ne_hit   = ~NE_SCLK;
  assign addr_hit = (bit_cnt_q >= CNT_W'(ADDR_FIRST)) && (bit_cnt_q <= CNT_W'(ADDR_FIRST + 2));
  assign addr_idx = 2'(CNT_W'(ADDR_FIRST + 2) - bit_cnt_q);

  always_ff @(posedge clk_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b1;
      din_q     <= 1'b0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      ch_q      <= '0;
    end else begin
      state_q   <= state_d;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      din_q     <= din_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      ch_q      <= ch_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cs_n_d    = cs_n_q;
    sclk_d    = sclk_q;
    din_d     = din_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    sample_d  = sample_q;
    valid_d   = 1'b0;
    busy_d    = busy_q;
    ch_d      = ch_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          ch_d    = channel;
          busy_d  = 1'b1;
          state_d = ARM;
        end
      end
      ARM: begin
        if (ne_hit) begin
          cs_n_d    = 1'b0;
          sclk_d    = 1'b0;
          bit_cnt_d = '0;
          din_d     = 1'b0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (ne_hit) begin
          sclk_d = 1'b0;
          din_d  = addr_hit ? ch_q[addr_idx] : 1'b0;
        end else if (PE_SCLK) begin
          sclk_d  = 1'b1;
          shift_d = {shift_q[DATA_W-3:0], dout_s};
          if (bit_cnt_q == CNT_W'(FRAME_BITS - 1)) begin
            sample_d = {shift_q, dout_s};
            valid_d  = 1'b1;
`ifdef ADC_CONT_EN
            if (start) begin
              bit_cnt_d = '0;
              ch_d      = channel;
            end else begin
              state_d = DONE;
            end
`else
            state_d = DONE;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        if (ne_hit) begin
          cs_n_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign adc.ADC_CS_N     = cs_n_q;
  assign adc.ADC_SCLK     = sclk_q;
  assign adc.ADC_DIN      = din_q;
  assign adc.sample       = sample_q;
  assign adc.sample_valid = valid_q;
  assign adc.busy         = busy_q;

endmodule

// File: tb/tb_adc_serial_rx.sv
// Bench for adc_serial_rx: strobe generator, ADC frame model, and a per-cycle output checker.
module tb_adc_serial_rx;
  import adc_pkg::*;

  localparam int PERIOD     = 24;
  localparam int PE_PH      = 0;
  localparam int NE_PH      = 11;
  localparam int GOOD_PH    = 22;
  localparam int LAT_NORMAL = 15 * PERIOD + (PERIOD - NE_PH) + PE_PH;

  logic       clk_clk = 1'b0;
  logic       reset_n;
  logic       PE_SCLK;
  logic       NE_SCLK;
  logic       start;
  logic [2:0] channel;

  adc_serial_rx_if adc ();

  adc_serial_rx dut (
    .clk_clk (clk_clk),
    .reset_n (reset_n),
    .PE_SCLK (PE_SCLK),
    .NE_SCLK (NE_SCLK),
    .start   (start),
    .channel (channel),
    .adc     (adc)
  );

  always #5 clk_clk = ~clk_clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Expectations shared between stimulus, ADC model and checker
  logic [11:0] adc_data_q[$];
  logic [11:0] exp_sample_q[$];
  logic [2:0]  exp_ch_q[$];

  bit glitch         = 1'b0;
  bit inject_pending = 1'b0;
  bit inject_active  = 1'b0;

  // Strobe generator and ADC: the ADC presents the next frame bit after each SCLK fall
  int          phase = 0;
  int          fall_cnt = 0;
  logic [15:0] cur_word = '0;
  logic        cur_bit = 1'b0;
  logic        prev_sclk_a = 1'b1;

  initial begin
    PE_SCLK = 1'b0;
    NE_SCLK = 1'b1;
    adc.ADC_DOUT = 1'b0;
    forever begin
      @(negedge clk_clk);
      if (!reset_n || adc.ADC_CS_N) begin
        fall_cnt = 0;
        cur_bit  = 1'b0;
      end else if (prev_sclk_a && !adc.ADC_SCLK) begin
        if (fall_cnt % 16 == 0)
          cur_word = (adc_data_q.size() > 0) ? {4'b0000, adc_data_q.pop_front()} : 16'h0000;
        cur_bit = cur_word[15 - (fall_cnt % 16)];
        fall_cnt++;
      end
      prev_sclk_a = adc.ADC_SCLK;
      adc.ADC_DOUT = (glitch && phase != GOOD_PH) ? ~cur_bit : cur_bit;

      if (phase == PE_PH) begin
        if (inject_pending) begin
          inject_pending = 1'b0;
          inject_active  = 1'b1;
          PE_SCLK = 1'b0;
        end else begin
          PE_SCLK = 1'b1;
        end
      end else if (phase == NE_PH && inject_active) begin
        inject_active = 1'b0;
        PE_SCLK = 1'b1;
      end else begin
        PE_SCLK = 1'b0;
      end
      NE_SCLK = (phase == NE_PH) ? 1'b0 : 1'b1;
      phase = (phase + 1) % PERIOD;
    end
  end

  // Checker state
  int          cyc = 0;
  int          rise_cnt = 0;
  int          rises_total = 0;
  int          valid_cnt = 0;
  int          cs_rise_cnt = 0;
  int          lat_cnt = 0;
  int          last_lat = 0;
  int          valid_last_cyc = 0;
  int          valid_prev_cyc = 0;
  int          idx;
  logic [2:0]  cur_ch = '0;
  logic [11:0] last_sample = '0;
  logic [11:0] exp_s;
  logic        exp_din;
  logic        prev_sclk_m = 1'b1;
  logic        prev_cs_m = 1'b1;
  logic        din_seen[16];

  initial begin
    forever begin
      @(negedge clk_clk);
      cyc++;
      if (!reset_n) begin
        rise_cnt    = 0;
        last_sample = '0;
        prev_sclk_m = 1'b1;
        prev_cs_m   = 1'b1;
      end else begin
        // ADC samples DIN on each SCLK rise; address bits sit at indices 2..4
        if (!prev_sclk_m && adc.ADC_SCLK && !adc.ADC_CS_N) begin
          idx = rise_cnt % 16;
          if (idx == 0) begin
            if (exp_ch_q.size() == 0) check("ch_model_underflow", 32'd0, 32'd1);
            else cur_ch = exp_ch_q.pop_front();
          end
          exp_din = (idx >= 2 && idx <= 4) ? cur_ch[4 - idx] : 1'b0;
          check("din", {31'd0, adc.ADC_DIN}, {31'd0, exp_din});
          din_seen[idx] = adc.ADC_DIN;
          rise_cnt++;
          rises_total++;
        end
        if (adc.ADC_CS_N) rise_cnt = 0;

        if (prev_cs_m && !adc.ADC_CS_N) lat_cnt = 0;
        else lat_cnt++;
        if (!prev_cs_m && adc.ADC_CS_N) cs_rise_cnt++;

        if (adc.sample_valid) begin
          if (exp_sample_q.size() == 0) begin
            check("sample_model_underflow", 32'd0, 32'd1);
          end else begin
            exp_s = exp_sample_q.pop_front();
            check("sample", {20'd0, adc.sample}, {20'd0, exp_s});
            last_sample = exp_s;
          end
          valid_cnt++;
          last_lat       = lat_cnt;
          valid_prev_cyc = valid_last_cyc;
          valid_last_cyc = cyc;
        end else begin
          check("sample_hold", {20'd0, adc.sample}, {20'd0, last_sample});
        end

        if (!adc.busy) begin
          check("idle_cs_n", {31'd0, adc.ADC_CS_N}, 32'd1);
          check("idle_sclk", {31'd0, adc.ADC_SCLK}, 32'd1);
        end
        prev_sclk_m = adc.ADC_SCLK;
        prev_cs_m   = adc.ADC_CS_N;
      end
    end
  end

  task automatic wait_busy(input logic lvl, input int budget, input string name);
    int n = 0;
    while (adc.busy !== lvl && n < budget) begin
      @(negedge clk_clk);
      n++;
    end
    check(name, {31'd0, adc.busy}, {31'd0, lvl});
  endtask

  task automatic run_frame(input logic [2:0] ch, input logic [11:0] data, input bit do_inject);
    exp_ch_q.push_back(ch);
    exp_sample_q.push_back(data);
    adc_data_q.push_back(data);
    channel = ch;
    start   = 1'b1;
    wait_busy(1'b1, 50, "accept");
    start = 1'b0;
    if (do_inject) begin
      repeat (100) @(negedge clk_clk);
      inject_pending = 1'b1;
    end
    wait_busy(1'b0, 1200, "frame_end");
  endtask

  int v0, r0, c0, gap;

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    channel = 3'b000;
    repeat (4) @(negedge clk_clk);
    check("rst_cs_n",  {31'd0, adc.ADC_CS_N},     32'd1);
    check("rst_sclk",  {31'd0, adc.ADC_SCLK},     32'd1);
    check("rst_din",   {31'd0, adc.ADC_DIN},      32'd0);
    check("rst_sample", {20'd0, adc.sample},      32'd0);
    check("rst_valid", {31'd0, adc.sample_valid}, 32'd0);
    check("rst_busy",  {31'd0, adc.busy},         32'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk_clk);

    // Basic frame: channel 101, data A5C
    v0 = valid_cnt; r0 = rises_total;
    run_frame(3'b101, 12'hA5C, 1'b0);
    repeat (2) @(negedge clk_clk);
    check("t2_sample", {20'd0, adc.sample}, 32'h0000_0A5C);
    check("t2_din_addr", {29'd0, din_seen[2], din_seen[3], din_seen[4]}, 32'd5);
    check("t2_sclk_rises", rises_total - r0, 32'd16);
    check("t2_valid_pulses", valid_cnt - v0, 32'd1);
    check("t2_latency", last_lat, 32'd373);
    check("t2_latency_formula", last_lat, LAT_NORMAL);

    // Asynchronous reset in the middle of a frame
    exp_ch_q.push_back(3'b011);
    exp_sample_q.push_back(12'h3C3);
    adc_data_q.push_back(12'h3C3);
    channel = 3'b011;
    start   = 1'b1;
    wait_busy(1'b1, 50, "t1_accept");
    start = 1'b0;
    repeat (150) @(negedge clk_clk);
    check("t1_mid_busy", {31'd0, adc.busy},     32'd1);
    check("t1_mid_cs_n", {31'd0, adc.ADC_CS_N}, 32'd0);
    #3 reset_n = 1'b0;
    #1;
    check("t1_cs_n",   {31'd0, adc.ADC_CS_N},     32'd1);
    check("t1_sclk",   {31'd0, adc.ADC_SCLK},     32'd1);
    check("t1_busy",   {31'd0, adc.busy},         32'd0);
    check("t1_sample", {20'd0, adc.sample},       32'd0);
    check("t1_valid",  {31'd0, adc.sample_valid}, 32'd0);
    exp_ch_q.delete();
    exp_sample_q.delete();
    adc_data_q.delete();
    repeat (2) @(negedge clk_clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk_clk);

    // DOUT only valid two cycles before each PE, inverted otherwise
    glitch = 1'b1;
    run_frame(3'b110, 12'h5A3, 1'b0);
    glitch = 1'b0;
    repeat (2) @(negedge clk_clk);
    check("t6_sample", {20'd0, adc.sample}, 32'h0000_05A3);

    // Coincident PE+NE mid-frame: the PE is lost, frame ends one period late
    v0 = valid_cnt;
    run_frame(3'b001, 12'h6B9, 1'b1);
    repeat (2) @(negedge clk_clk);
    check("t4_sample", {20'd0, adc.sample}, 32'h0000_06B9);
    check("t4_latency", last_lat, 32'd397);
    check("t4_valid_pulses", valid_cnt - v0, 32'd1);

`ifdef ADC_CONT_EN
    // Continuous frames: CS_N held low across the boundary
    v0 = valid_cnt; c0 = cs_rise_cnt;
    exp_ch_q.push_back(3'b101);    exp_ch_q.push_back(3'b101);
    exp_sample_q.push_back(12'h001); exp_sample_q.push_back(12'hFFF);
    adc_data_q.push_back(12'h001);   adc_data_q.push_back(12'hFFF);
    channel = 3'b101;
    start   = 1'b1;
    wait_busy(1'b1, 50, "t5_accept");
    gap = 0;
    while (valid_cnt == v0 && gap < 1000) begin
      @(negedge clk_clk);
      gap++;
    end
    check("t5_first_valid", valid_cnt - v0, 32'd1);
    check("t5_first_sample", {20'd0, adc.sample}, 32'h0000_0001);
    start = 1'b0;
    wait_busy(1'b0, 1200, "t5_end");
    check("t5_valid_pulses", valid_cnt - v0, 32'd2);
    check("t5_spacing", valid_last_cyc - valid_prev_cyc, 32'd384);
    check("t5_cs_rises", cs_rise_cnt - c0, 32'd1);
    check("t5_last_sample", {20'd0, adc.sample}, 32'h0000_0FFF);
`else
    // start held through the frame; channel change must not affect it
    v0 = valid_cnt; c0 = cs_rise_cnt;
    exp_ch_q.push_back(3'b101);      exp_ch_q.push_back(3'b010);
    exp_sample_q.push_back(12'h111); exp_sample_q.push_back(12'h222);
    adc_data_q.push_back(12'h111);   adc_data_q.push_back(12'h222);
    channel = 3'b101;
    start   = 1'b1;
    wait_busy(1'b1, 50, "t3_accept");
    repeat (5) @(negedge clk_clk);
    channel = 3'b010;
    wait_busy(1'b0, 1200, "t3_first_end");
    gap = 0;
    while (adc.busy !== 1'b1 && gap < 50) begin
      @(negedge clk_clk);
      gap++;
    end
    check("t3_idle_gap", gap, 32'd1);
    start = 1'b0;
    wait_busy(1'b0, 1200, "t3_second_end");
    check("t3_valid_pulses", valid_cnt - v0, 32'd2);
    check("t3_cs_rises", cs_rise_cnt - c0, 32'd2);
    check("t3_last_sample", {20'd0, adc.sample}, 32'h0000_0222);
`endif

    repeat (30) @(negedge clk_clk);
    check("model_samples_left", exp_sample_q.size(), 32'd0);
    check("model_ch_left", exp_ch_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end

endmodule
